// File: rtl/dmem_arbiter.sv
// Shares one data_mem port among operand-fetch read (rd0), exec read (rd1)
// and writeback write (wr). Round-robin grant, strobe sequencing towards
// data_mem, and a timeout that aborts transactions data_mem never answers.
//
// Handshake: a requester raises req with a stable address (and write data)
// and holds it until its done pulses for exactly one cycle; err qualifies
// that same done pulse as a timeout. Towards data_mem a strobe (mem_in or
// mem_write) is held with stable address/data until mem_out is seen, then
// dropped for at least one cycle so data_mem can clear mem_out.
module dmem_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd0_req,
    input  logic [AW-1:0] rd0_adr,
    output logic [DW-1:0] rd0_data,
    output logic          rd0_done,
    input  logic          rd1_req,
    input  logic [AW-1:0] rd1_adr,
    output logic [DW-1:0] rd1_data,
    output logic          rd1_done,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_wdata,
    output logic          wr_done,
    output logic          err,
    output logic          mem_in,
    output logic [AW-1:0] mem_adr,
    output logic          mem_write,
    output logic [AW-1:0] mem_adr_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_out,
    output logic [1:0]    dbg_state_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_WRITE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    rr_q, rr_d;      // last granted: 0=rd0, 1=rd1, 2=wr
    logic [1:0]    win_q, win_d;    // requester owning the current transaction
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_in_q, mem_in_d;
    logic [AW-1:0] mem_adr_q, mem_adr_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_adr_write_q, mem_adr_write_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rd0_data_q, rd0_data_d;
    logic [DW-1:0] rd1_data_q, rd1_data_d;
    logic          rd0_done_q, rd0_done_d;
    logic          rd1_done_q, rd1_done_d;
    logic          wr_done_q, wr_done_d;
    logic          err_q, err_d;

    logic [2:0]    req_vec;
    logic [1:0]    c0, c1, c2;
    logic          gnt_vld;
    logic [1:0]    gnt_id;
    logic          fin;
    logic          timed_out;

    // Round-robin pick: search starts just after the last granted requester.
    always_comb begin
        req_vec = {wr_req, rd1_req, rd0_req};
        case (rr_q)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        gnt_vld = |req_vec;
        if (req_vec[c0])      gnt_id = c0;
        else if (req_vec[c1]) gnt_id = c1;
        else                  gnt_id = c2;
    end

    // Next-state and registered-output logic of the transaction FSM.
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        win_d           = win_q;
        cnt_d           = cnt_q;
        mem_in_d        = mem_in_q;
        mem_adr_d       = mem_adr_q;
        mem_write_d     = mem_write_q;
        mem_adr_write_d = mem_adr_write_q;
        mem_wdata_d     = mem_wdata_q;
        rd0_data_d      = rd0_data_q;
        rd1_data_d      = rd1_data_q;
        rd0_done_d      = 1'b0;
        rd1_done_d      = 1'b0;
        wr_done_d       = 1'b0;
        err_d           = 1'b0;
        fin             = 1'b0;
        timed_out       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    win_d = gnt_id;
                    rr_d  = gnt_id;
                    cnt_d = '0;
                    if (gnt_id == 2'd2) begin
                        state_d         = S_WRITE;
                        mem_write_d     = 1'b1;
                        mem_adr_write_d = wr_adr;
                        mem_wdata_d     = wr_wdata;
                    end else begin
                        state_d   = S_READ;
                        mem_in_d  = 1'b1;
                        mem_adr_d = (gnt_id == 2'd0) ? rd0_adr : rd1_adr;
                    end
                end
            end
            S_READ, S_WRITE: begin
                if (mem_out) begin
                    fin = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    fin       = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (fin) begin
                    state_d     = S_RELEASE;
                    mem_in_d    = 1'b0;
                    mem_write_d = 1'b0;
                    err_d       = timed_out;
                    // An aborted read returns zero rather than stale bus data.
                    if (state_q == S_READ) begin
                        if (win_q == 2'd0) rd0_data_d = timed_out ? '0 : mem_rdata;
                        else               rd1_data_d = timed_out ? '0 : mem_rdata;
                    end
                    case (win_q)
                        2'd0:    rd0_done_d = 1'b1;
                        2'd1:    rd1_done_d = 1'b1;
                        default: wr_done_d  = 1'b1;
                    endcase
                end
            end
            default: begin
                // RELEASE: strobes are already low; give data_mem one cycle.
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rr_q            <= 2'd2;
            win_q           <= 2'd0;
            cnt_q           <= '0;
            mem_in_q        <= 1'b0;
            mem_adr_q       <= '0;
            mem_write_q     <= 1'b0;
            mem_adr_write_q <= '0;
            mem_wdata_q     <= '0;
            rd0_data_q      <= '0;
            rd1_data_q      <= '0;
            rd0_done_q      <= 1'b0;
            rd1_done_q      <= 1'b0;
            wr_done_q       <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            win_q           <= win_d;
            cnt_q           <= cnt_d;
            mem_in_q        <= mem_in_d;
            mem_adr_q       <= mem_adr_d;
            mem_write_q     <= mem_write_d;
            mem_adr_write_q <= mem_adr_write_d;
            mem_wdata_q     <= mem_wdata_d;
            rd0_data_q      <= rd0_data_d;
            rd1_data_q      <= rd1_data_d;
            rd0_done_q      <= rd0_done_d;
            rd1_done_q      <= rd1_done_d;
            wr_done_q       <= wr_done_d;
            err_q           <= err_d;
        end
    end

    assign rd0_data      = rd0_data_q;
    assign rd0_done      = rd0_done_q;
    assign rd1_data      = rd1_data_q;
    assign rd1_done      = rd1_done_q;
    assign wr_done       = wr_done_q;
    assign err           = err_q;
    assign mem_in        = mem_in_q;
    assign mem_adr       = mem_adr_q;
    assign mem_write     = mem_write_q;
    assign mem_adr_write = mem_adr_write_q;
    assign mem_wdata     = mem_wdata_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a data_mem responder model with programmable
// latency, directed scenarios, and randomized request rounds checked
// against a transaction-order/memory-contents reference model.
module tb_dmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd0_req = 0, rd1_req = 0, wr_req = 0;
  logic [AW-1:0] rd0_adr = '0, rd1_adr = '0, wr_adr = '0;
  logic [DW-1:0] wr_wdata = '0;
  logic [DW-1:0] rd0_data, rd1_data, mem_wdata, mem_rdata;
  logic rd0_done, rd1_done, wr_done, err, mem_in, mem_write, mem_out;
  logic [AW-1:0] mem_adr, mem_adr_write;
  logic [1:0] dbg_state;

  logic resp_out = 0;
  logic force_out = 0;
  logic no_resp = 0;
  int lat_fix = 1;
  assign mem_out = resp_out | force_out;

  logic [DW-1:0] memory [32];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_q[$];
  logic [1:0] exp_id_q[$];

  int total = 0;
  int bad = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rd0_req(rd0_req), .rd0_adr(rd0_adr), .rd0_data(rd0_data), .rd0_done(rd0_done),
    .rd1_req(rd1_req), .rd1_adr(rd1_adr), .rd1_data(rd1_data), .rd1_done(rd1_done),
    .wr_req(wr_req), .wr_adr(wr_adr), .wr_wdata(wr_wdata), .wr_done(wr_done),
    .err(err), .mem_in(mem_in), .mem_adr(mem_adr), .mem_write(mem_write),
    .mem_adr_write(mem_adr_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_out(mem_out), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // data_mem responder: answers after lat strobe cycles, holds mem_out
  // until the strobe drops
  initial begin
    int scnt;
    int lat;
    scnt = 0;
    lat = 1;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_in || mem_write) begin
        if (scnt == 0) lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
        scnt++;
        if (!no_resp && scnt >= lat) begin
          resp_out = 1'b1;
          if (mem_write) memory[mem_adr_write] = mem_wdata;
          else mem_rdata = memory[mem_adr];
        end
      end else begin
        scnt = 0;
        resp_out = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    rd0_req = 0; rd1_req = 0; wr_req = 0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rd0_data !== '0) begin bad++; $display("FAIL reset_rd0_data got=%h exp=0", rd0_data); end
    total++; if (rd1_data !== '0) begin bad++; $display("FAIL reset_rd1_data got=%h exp=0", rd1_data); end
    total++; if ({rd0_done, rd1_done, wr_done, err, mem_in, mem_write} !== 6'b0)
      begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {rd0_done, rd1_done, wr_done, err, mem_in, mem_write}); end
    total++; if ({mem_adr, mem_adr_write, mem_wdata} !== '0)
      begin bad++; $display("FAIL reset_bus got=%h exp=0", {mem_adr, mem_adr_write, mem_wdata}); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (dbg_state !== ST_IDLE || mem_in !== 1'b0)
      begin bad++; $display("FAIL idle_no_req got=%0d/%b exp=0/0", dbg_state, mem_in); end
  endtask

  task automatic test_basic_read();
    int scnt;
    bit seen;
    memory[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    lat_fix = 2; no_resp = 0;
    rd0_adr = 5'd5; rd0_req = 1'b1;
    scnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_in) begin
        scnt++;
        total++; if (mem_adr !== 5'd5) begin bad++; $display("FAIL read_adr got=%0d exp=5", mem_adr); end
      end
      if (rd0_done || rd1_done || wr_done) seen = 1;
    end
    rd0_req = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL read_done_timeout got=0 exp=1"); end
    total++; if ({rd0_done, rd1_done, wr_done} !== 3'b100) begin bad++; $display("FAIL read_done got=%b exp=100", {rd0_done, rd1_done, wr_done}); end
    total++; if (rd0_data !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h exp=deadbeef", rd0_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL read_err got=%b exp=0", err); end
    total++; if (scnt != 2) begin bad++; $display("FAIL read_strobe_len got=%0d exp=2", scnt); end
    total++; if (dbg_state !== ST_RELEASE) begin bad++; $display("FAIL read_release got=%0d exp=3", dbg_state); end
    @(negedge clk);
    total++; if (rd0_done !== 1'b0 || dbg_state !== ST_IDLE)
      begin bad++; $display("FAIL read_after got=%b/%0d exp=0/0", rd0_done, dbg_state); end
  endtask

  task automatic test_write_then_read();
    int wcnt;
    bit seen;
    lat_fix = 1; no_resp = 0;
    wr_adr = 5'd3; wr_wdata = 32'h12345678; wr_req = 1'b1;
    wcnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_write) begin
        wcnt++;
        total++; if (mem_adr_write !== 5'd3 || mem_wdata !== 32'h12345678)
          begin bad++; $display("FAIL write_bus got=%0d/%h exp=3/12345678", mem_adr_write, mem_wdata); end
      end
      if (rd0_done || rd1_done || wr_done) seen = 1;
    end
    wr_req = 1'b0;
    ref_mem[3] = 32'h12345678;
    total++; if ({rd0_done, rd1_done, wr_done, err} !== 4'b0010)
      begin bad++; $display("FAIL write_done got=%b exp=0010", {rd0_done, rd1_done, wr_done, err}); end
    total++; if (wcnt != 1) begin bad++; $display("FAIL write_strobe_len got=%0d exp=1", wcnt); end
    @(negedge clk);
    rd1_adr = 5'd3; rd1_req = 1'b1; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rd0_done || rd1_done || wr_done) seen = 1;
    end
    rd1_req = 1'b0;
    total++; if ({rd0_done, rd1_done, wr_done, err} !== 4'b0100)
      begin bad++; $display("FAIL rd1_done got=%b exp=0100", {rd0_done, rd1_done, wr_done, err}); end
    total++; if (rd1_data !== ref_mem[3]) begin bad++; $display("FAIL rd1_data got=%h exp=%h", rd1_data, ref_mem[3]); end
    total++; if (rd0_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd0_hold got=%h exp=deadbeef", rd0_data); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int k;
    logic [2:0] d;
    logic [1:0] id;
    rst = 1'b1;
    lat_fix = 1; no_resp = 0;
    rd0_adr = 5'd1; rd1_adr = 5'd2; wr_adr = 5'd7; wr_wdata = 32'hA5A50F0F;
    ref_mem[7] = 32'hA5A50F0F;
    rd0_req = 1; rd1_req = 1; wr_req = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 200 && k < 9; i++) begin
      @(negedge clk);
      d = {wr_done, rd1_done, rd0_done};
      if (d != 3'b0) begin
        total++;
        if ($countones(d) != 1) begin bad++; $display("FAIL rr_multi_done got=%b exp=onehot", d); end
        id = d[0] ? 2'd0 : (d[1] ? 2'd1 : 2'd2);
        if (id != 2'(k % 3)) begin bad++; $display("FAIL rr_order got=%0d exp=%0d", id, k % 3); end
        total++;
        if (err !== 1'b0 || (id == 0 && rd0_data !== ref_mem[1]) || (id == 1 && rd1_data !== ref_mem[2]))
          begin bad++; $display("FAIL rr_data id=%0d got=%h/%h err=%b", id, rd0_data, rd1_data, err); end
        k++;
      end
    end
    rd0_req = 0; rd1_req = 0; wr_req = 0;
    total++; if (k != 9) begin bad++; $display("FAIL rr_count got=%0d exp=9", k); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int scnt;
    bit seen;
    no_resp = 1;
    rd0_adr = 5'd4; rd0_req = 1'b1;
    scnt = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (mem_in) scnt++;
      if (rd0_done || rd1_done || wr_done) seen = 1;
    end
    rd0_req = 1'b0;
    total++; if (scnt != 16) begin bad++; $display("FAIL to_strobe_len got=%0d exp=16", scnt); end
    total++; if ({rd0_done, rd1_done, wr_done, err} !== 4'b1001)
      begin bad++; $display("FAIL to_done_err got=%b exp=1001", {rd0_done, rd1_done, wr_done, err}); end
    total++; if (rd0_data !== '0) begin bad++; $display("FAIL to_data got=%h exp=0", rd0_data); end
    total++; if (dbg_state !== ST_RELEASE) begin bad++; $display("FAIL to_release got=%0d exp=3", dbg_state); end
    @(negedge clk);
    total++; if (dbg_state !== ST_IDLE || err !== 1'b0 || rd0_done !== 1'b0)
      begin bad++; $display("FAIL to_idle got=%0d/%b/%b exp=0/0/0", dbg_state, err, rd0_done); end
    no_resp = 0;
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    logic [2:0] d;
    no_resp = 1;
    wr_adr = 5'd9; wr_wdata = 32'hCAFEF00D; wr_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_write) seen = 1;
    end
    @(negedge clk);
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rmw_pre got=%b exp=1", mem_write); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr_req = 1'b0;
    total++; if ({mem_write, wr_done, err} !== 3'b000 || dbg_state !== ST_IDLE)
      begin bad++; $display("FAIL rmw_abort got=%b/%0d exp=000/0", {mem_write, wr_done, err}, dbg_state); end
    no_resp = 0; lat_fix = 1; seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd0_done || rd1_done || wr_done) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL rmw_stray_done got=1 exp=0"); end
    rd0_adr = 5'd6; rd1_adr = 5'd2; wr_adr = 5'd8;
    rd0_req = 1; rd1_req = 1; wr_req = 1;
    d = 3'b0;
    for (int i = 0; i < 40 && d == 3'b0; i++) begin
      @(negedge clk);
      d = {wr_done, rd1_done, rd0_done};
    end
    rd0_req = 0; rd1_req = 0; wr_req = 0;
    total++; if (d !== 3'b001) begin bad++; $display("FAIL rmw_first_grant got=%b exp=001", d); end
    total++; if (rd0_data !== ref_mem[6]) begin bad++; $display("FAIL rmw_data got=%h exp=%h", rd0_data, ref_mem[6]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_idle_mem_out();
    force_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({rd0_done, rd1_done, wr_done, err, mem_in, mem_write} !== 6'b0 || dbg_state !== ST_IDLE)
        begin bad++; $display("FAIL idle_mem_out got=%b/%0d exp=000000/0", {rd0_done, rd1_done, wr_done, err, mem_in, mem_write}, dbg_state); end
    end
    force_out = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_rounds();
    int last;
    int sub;
    logic [2:0] d;
    logic [1:0] id;
    logic [AW-1:0] a0, a1, aw;
    logic [DW-1:0] wd;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last = 2;
    lat_fix = 0; no_resp = 0;
    for (int r = 0; r < 25; r++) begin
      sub = int'($urandom_range(1, 7));
      a0 = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7));
      aw = 5'($urandom_range(0, 7)); wd = $urandom;
      exp_q.delete(); exp_id_q.delete();
      for (int s = 1; s <= 3; s++) begin
        int c;
        c = (last + s) % 3;
        if (sub[c]) begin
          exp_id_q.push_back(2'(c));
          if (c == 2) begin ref_mem[aw] = wd; exp_q.push_back('0); end
          else exp_q.push_back(ref_mem[(c == 0) ? a0 : a1]);
        end
      end
      last = int'(exp_id_q[exp_id_q.size() - 1]);
      rd0_adr = a0; rd1_adr = a1; wr_adr = aw; wr_wdata = wd;
      rd0_req = sub[0]; rd1_req = sub[1]; wr_req = sub[2];
      for (int i = 0; i < 100 && exp_id_q.size() > 0; i++) begin
        @(negedge clk);
        d = {wr_done, rd1_done, rd0_done};
        if (d != 3'b0) begin
          total++;
          id = d[0] ? 2'd0 : (d[1] ? 2'd1 : 2'd2);
          if ($countones(d) != 1 || id != exp_id_q[0])
            begin bad++; $display("FAIL rnd_order round=%0d got=%b exp_id=%0d", r, d, exp_id_q[0]); end
          total++;
          if (err !== 1'b0 || (id == 0 && rd0_data !== exp_q[0]) || (id == 1 && rd1_data !== exp_q[0]))
            begin bad++; $display("FAIL rnd_data round=%0d id=%0d got=%h exp=%h err=%b", r, id,
                                  (id == 0) ? rd0_data : rd1_data, exp_q[0], err); end
          void'(exp_id_q.pop_front());
          void'(exp_q.pop_front());
          if (id == 0) rd0_req = 0;
          else if (id == 1) rd1_req = 0;
          else wr_req = 0;
        end
      end
      total++; if (exp_id_q.size() != 0) begin bad++; $display("FAIL rnd_timeout round=%0d left=%0d exp=0", r, exp_id_q.size()); end
      rd0_req = 0; rd1_req = 0; wr_req = 0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      memory[i] = $urandom | 32'h1;
      ref_mem[i] = memory[i];
    end
    test_reset();
    test_basic_read();
    test_write_then_read();
    test_round_robin();
    test_timeout();
    test_reset_mid_write();
    test_idle_mem_out();
    test_random_rounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
